// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants: 640x480@60 defaults and total-count derivation.
package vga_timing_pkg;

  // Sum of the four timing segments of one axis.
  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // 640x480@60 horizontal timing, pixels.
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;

  // 640x480@60 vertical timing, lines.
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  // Sync active levels (0 = active-low).
  localparam bit HS_POL = 1'b0;
  localparam bit VS_POL = 1'b0;

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Counter widths carried on the raster bus and the largest totals they hold.
  localparam int unsigned HCOUNT_W    = 11;
  localparam int unsigned VCOUNT_W    = 10;
  localparam int unsigned H_TOTAL_MAX = 2048;
  localparam int unsigned V_TOTAL_MAX = 1024;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bus from the timing generator to the pattern stage and DAC pins.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic [HCOUNT_W-1:0] hcount;
  logic [VCOUNT_W-1:0] vcount;
  logic                hsync;
  logic                vsync;
  logic                video_on;
  logic                line_start;
  logic                frame_start;

  modport master (
    output hcount, vcount, hsync, vsync, video_on, line_start, frame_start
  );

  modport slave (
    input hcount, vcount, hsync, vsync, video_on, line_start, frame_start
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync decode.
// active is a lookahead flag: it decodes the value count will take on this edge,
// so a register loaded from it lines up with count with no relative latency.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = H_ACTIVE,
  parameter int unsigned FP     = H_FP,
  parameter int unsigned SYNC   = H_SYNC,
  parameter int unsigned BP     = H_BP,
  parameter bit          POL    = HS_POL,
  parameter int unsigned WIDTH  = HCOUNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             sync,
  output logic             active,
  output logic             wrap
);

  localparam int unsigned TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam int unsigned CAPACITY   = 32'd1 << WIDTH;
  localparam int unsigned SYNC_FIRST = ACTIVE + FP;
  localparam int unsigned SYNC_LAST  = ACTIVE + FP + SYNC - 1;

  // Reject timings the counter cannot represent.
  if (TOTAL > CAPACITY) begin : g_total_check
    $error("vga_axis_counter: total %0d exceeds %0d-bit counter", TOTAL, WIDTH);
  end
  if (SYNC == 0) begin : g_sync_check
    $error("vga_axis_counter: sync width must be non-zero");
  end

  logic [WIDTH-1:0] count_nxt;
  logic             sync_nxt;

  // Terminal count, next position and decodes of the next position.
  always_comb begin
    wrap      = (count == WIDTH'(TOTAL - 1));
    count_nxt = count;
    if (en) begin
      count_nxt = wrap ? '0 : count + WIDTH'(1);
    end
    active   = (count_nxt < WIDTH'(ACTIVE));
    sync_nxt = ((count_nxt >= WIDTH'(SYNC_FIRST)) && (count_nxt <= WIDTH'(SYNC_LAST))) ? POL : ~POL;
  end

  // Position and sync level; both hold while en is low since count_nxt == count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      sync  <= ~POL;
    end else begin
      count <= count_nxt;
      sync  <= sync_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: horizontal/vertical counters, syncs, video enable and
// line/frame start pulses, all registered.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
  parameter bit          HS_POL   = vga_timing_pkg::HS_POL,
  parameter bit          VS_POL   = vga_timing_pkg::VS_POL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_ce,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned LINE_TOTAL  = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned FRAME_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Reject timings outside the range of the raster bus counters.
  if (LINE_TOTAL > H_TOTAL_MAX) begin : g_h_range
    $error("vga_timing_gen: H_TOTAL %0d exceeds %0d", LINE_TOTAL, H_TOTAL_MAX);
  end
  if (FRAME_TOTAL > V_TOTAL_MAX) begin : g_v_range
    $error("vga_timing_gen: V_TOTAL %0d exceeds %0d", FRAME_TOTAL, V_TOTAL_MAX);
  end

  logic [HCOUNT_W-1:0] h_count;
  logic [VCOUNT_W-1:0] v_count;
  logic                h_sync;
  logic                v_sync;
  logic                h_active;
  logic                v_active;
  logic                h_wrap;
  logic                v_wrap;
  logic                v_en;
  logic                video_on;
  logic                line_start;
  logic                frame_start;

  // Lines advance only on the pixel edge that wraps the column counter.
  assign v_en = pix_ce & h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL),
    .WIDTH  (HCOUNT_W)
  ) u_h_axis (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (pix_ce),
    .count  (h_count),
    .sync   (h_sync),
    .active (h_active),
    .wrap   (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL),
    .WIDTH  (VCOUNT_W)
  ) u_v_axis (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (v_en),
    .count  (v_count),
    .sync   (v_sync),
    .active (v_active),
    .wrap   (v_wrap)
  );

  // Video enable follows the counters on pixel edges; pulses mark loads of column/frame 0.
  // video_on stays low after reset until the first pixel edge, blanking pixel (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (pix_ce) begin
        video_on <= h_active & v_active;
      end
      line_start  <= pix_ce & h_wrap;
      frame_start <= pix_ce & h_wrap & v_wrap;
    end
  end

  assign vga.hcount      = h_count;
  assign vga.vcount      = v_count;
  assign vga.hsync       = h_sync;
  assign vga.vsync       = v_sync;
  assign vga.video_on    = video_on;
  assign vga.line_start  = line_start;
  assign vga.frame_start = frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 800-pixel lines, shortened 30-line frame.
module tb_vga_timing_gen;

  localparam int HT  = 800;
  localparam int VA  = 20;
  localparam int VFP = 3;
  localparam int VS  = 2;
  localparam int VBP = 5;
  localparam int VT  = VA + VFP + VS + VBP;

  logic clk = 1'b0;
  logic rst_n;
  logic pix_ce;

  int checks   = 0;
  int failures = 0;

  // Reference raster position and pulse expectations.
  int mh;
  int mv;
  bit started;
  bit m_ls;
  bit m_fs;

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .V_ACTIVE (VA),
    .V_FP     (VFP),
    .V_SYNC   (VS),
    .V_BP     (VBP)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_ce (pix_ce),
    .vga    (vif)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] vec(input int h, input int v, input bit hs, input bit vs,
                                      input bit vo, input bit ls, input bit fs);
    return 32'({11'(h), 10'(v), hs, vs, vo, ls, fs});
  endfunction

  function automatic logic [31:0] dut_vec();
    return 32'({vif.hcount, vif.vcount, vif.hsync, vif.vsync, vif.video_on,
                vif.line_start, vif.frame_start});
  endfunction

  function automatic logic [31:0] model_vec();
    bit hs;
    bit vs;
    bit vo;
    hs = !(mh >= 656 && mh <= 751);
    vs = !(mv >= VA + VFP && mv <= VA + VFP + VS - 1);
    vo = started && (mh < 640) && (mv < VA);
    return vec(mh, mv, hs, vs, vo, m_ls, m_fs);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; started = 0; m_ls = 0; m_fs = 0;
  endtask

  // One clock: drive pix_ce, advance the reference, compare the whole bus.
  task automatic tick(input bit ce);
    pix_ce = ce;
    @(posedge clk);
    #1;
    m_ls = 0;
    m_fs = 0;
    if (!rst_n) begin
      model_reset();
    end else if (ce) begin
      started = 1;
      if (mh == HT - 1) begin
        mh   = 0;
        mv   = (mv == VT - 1) ? 0 : mv + 1;
        m_ls = 1;
        m_fs = (mv == 0);
      end else begin
        mh++;
      end
    end
    chk("cycle", dut_vec(), model_vec());
  endtask

  task automatic run_to(input int h, input int v);
    for (int i = 0; i < 30000 && !(mh == h && mv == v); i++) tick(1'b1);
  endtask

  initial begin
    int first;
    int second;
    int n_ls;
    int n_fs;

    rst_n  = 1'b0;
    pix_ce = 1'b0;
    model_reset();

    // Held in reset while pix_ce toggles.
    for (int i = 0; i < 6; i++) tick(i[0]);
    chk("reset_values", dut_vec(), vec(0, 0, 1, 1, 0, 0, 0));

    // Release; idle without pix_ce, then first pixel edge.
    rst_n = 1'b1;
    tick(1'b0);
    tick(1'b0);
    chk("idle_hold", dut_vec(), vec(0, 0, 1, 1, 0, 0, 0));
    tick(1'b1);
    chk("first_ce", dut_vec(), vec(1, 0, 1, 1, 1, 0, 0));

    // Horizontal active/sync boundaries.
    run_to(639, 0);
    chk("h639", dut_vec(), vec(639, 0, 1, 1, 1, 0, 0));
    tick(1'b1);
    chk("video_off_640", dut_vec(), vec(640, 0, 1, 1, 0, 0, 0));
    run_to(655, 0);
    chk("hsync_655", dut_vec(), vec(655, 0, 1, 1, 0, 0, 0));
    tick(1'b1);
    chk("hsync_656", dut_vec(), vec(656, 0, 0, 1, 0, 0, 0));
    run_to(751, 0);
    chk("hsync_751", dut_vec(), vec(751, 0, 0, 1, 0, 0, 0));
    tick(1'b1);
    chk("hsync_752", dut_vec(), vec(752, 0, 1, 1, 0, 0, 0));

    // Line wraps.
    run_to(799, 0);
    tick(1'b1);
    chk("line_wrap0", dut_vec(), vec(0, 1, 1, 1, 1, 1, 0));
    tick(1'b1);
    chk("ls_one_clk", dut_vec(), vec(1, 1, 1, 1, 1, 0, 0));
    run_to(799, 9);
    tick(1'b1);
    chk("line_wrap9", dut_vec(), vec(0, 10, 1, 1, 1, 1, 0));

    // Vertical active/sync boundaries (vsync lines 23..24).
    run_to(799, 19);
    tick(1'b1);
    chk("vactive_end", dut_vec(), vec(0, 20, 1, 1, 0, 1, 0));
    run_to(799, 22);
    chk("vsync_pre", dut_vec(), vec(799, 22, 1, 1, 0, 0, 0));
    tick(1'b1);
    chk("vsync_on", dut_vec(), vec(0, 23, 1, 0, 0, 1, 0));
    run_to(700, 23);
    chk("vsync_mid", dut_vec(), vec(700, 23, 0, 0, 0, 0, 0));
    run_to(799, 24);
    tick(1'b1);
    chk("vsync_off", dut_vec(), vec(0, 25, 1, 1, 0, 1, 0));

    // Frame wrap.
    run_to(799, VT - 1);
    tick(1'b1);
    chk("frame_wrap", dut_vec(), vec(0, 0, 1, 1, 1, 1, 1));
    tick(1'b1);
    chk("fs_one_clk", dut_vec(), vec(1, 0, 1, 1, 1, 0, 0));

    // Half-rate pixel enable: line period in clocks.
    first  = -1;
    second = -1;
    for (int i = 0; i < 4000; i++) begin
      tick(i[0]);
      if (vif.line_start === 1'b1) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    chk("line_period", 32'(second - first), 32'd1600);

    // Asynchronous reset mid-frame.
    run_to(300, 10);
    chk("pre_reset", dut_vec(), vec(300, 10, 1, 1, 1, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", dut_vec(), vec(0, 0, 1, 1, 0, 0, 0));
    model_reset();
    tick(1'b1);
    tick(1'b1);
    rst_n = 1'b1;

    // Full frame after release.
    n_ls = 0;
    n_fs = 0;
    for (int i = 0; i < HT * VT; i++) begin
      tick(1'b1);
      if (vif.line_start === 1'b1) n_ls++;
      if (vif.frame_start === 1'b1) n_fs++;
    end
    chk("frame_after_reset", dut_vec(), vec(0, 0, 1, 1, 1, 1, 1));
    chk("line_pulse_count", 32'(n_ls), 32'(VT));
    chk("frame_pulse_count", 32'(n_fs), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
